// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and global hold.
// Optional bubble counter output bubble_cnt_o is enabled by defining ID_EX_PERF_EN.
module id_ex_pipe #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              hold_i,
   input  logic              flush_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic [DATA_W-1:0] id_data1_i,
   input  logic [DATA_W-1:0] id_data2_i,
   input  logic [DATA_W-1:0] id_imm_i,
   input  logic [8:0]        id_ctrl_i,
   output logic              stall_o,
   output logic              ex_valid_o,
   output logic [REG_AW-1:0] ex_rs_o,
   output logic [REG_AW-1:0] ex_rt_o,
   output logic [REG_AW-1:0] ex_rd_o,
   output logic [DATA_W-1:0] ex_data1_o,
   output logic [DATA_W-1:0] ex_data2_o,
   output logic [DATA_W-1:0] ex_imm_o,
`ifdef ID_EX_PERF_EN
   output logic [31:0]       bubble_cnt_o,
`endif
   output logic [7:0]        ex_ctrl_o
);

   // Bit position of MemRead within ex_ctrl_o (id_ctrl_i shifted right by one).
   localparam int MEMREAD_BIT = 5;

   logic uses_rt;
   logic rt_match;
   logic hazard;

   assign uses_rt  = id_ctrl_i[0];
   assign rt_match = (ex_rt_o == id_rs_i) | (uses_rt & (ex_rt_o == id_rt_i));
   assign hazard   = ex_valid_o & ex_ctrl_o[MEMREAD_BIT] & (ex_rt_o != '0) & rt_match;

   // Reset clears ex_valid_o, so hazard and stall_o are already 0 in reset.
   assign stall_o = hazard & ~flush_i & ~hold_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ex_valid_o <= 1'b0;
         ex_rs_o    <= '0;
         ex_rt_o    <= '0;
         ex_rd_o    <= '0;
         ex_data1_o <= '0;
         ex_data2_o <= '0;
         ex_imm_o   <= '0;
         ex_ctrl_o  <= '0;
      end else if (hold_i) begin
         // NOTE: holding a value in a clocked block is just a flop enable; no latch results.
         ex_valid_o <= ex_valid_o;
      end else if (flush_i || hazard) begin
         ex_valid_o <= 1'b0;
         ex_rs_o    <= '0;
         ex_rt_o    <= '0;
         ex_rd_o    <= '0;
         ex_data1_o <= '0;
         ex_data2_o <= '0;
         ex_imm_o   <= '0;
         ex_ctrl_o  <= '0;
      end else begin
         ex_valid_o <= 1'b1;
         ex_rs_o    <= id_rs_i;
         ex_rt_o    <= id_rt_i;
         ex_rd_o    <= id_rd_i;
         ex_data1_o <= id_data1_i;
         ex_data2_o <= id_data2_i;
         ex_imm_o   <= id_imm_i;
         ex_ctrl_o  <= id_ctrl_i[8:1];
      end
   end

`ifdef ID_EX_PERF_EN
   // Only hazard bubbles count; flush has priority, so a flushed hazard is not counted.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         bubble_cnt_o <= '0;
      end else if (!hold_i && !flush_i && hazard) begin
         bubble_cnt_o <= bubble_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed self-checking bench for id_ex_pipe; bubble counter checks apply when ID_EX_PERF_EN is defined.
module tb_id_ex_pipe;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;

   // Control encodings {RegWrite, MemToReg, MemRead, MemWrite, ALUSrc, RegDst, ALUOp[1:0], uses_rt}
   localparam logic [8:0] C_ADD  = 9'h109;  // RegWrite|RegDst|uses_rt -> ex 0x84
   localparam logic [8:0] C_PASS = 9'h108;  // RegWrite|RegDst         -> ex 0x84
   localparam logic [8:0] C_LW   = 9'h1D0;  // RegWrite|MemToReg|MemRead|ALUSrc -> ex 0xE8

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              hold_i;
   logic              flush_i;
   logic [REG_AW-1:0] id_rs_i, id_rt_i, id_rd_i;
   logic [DATA_W-1:0] id_data1_i, id_data2_i, id_imm_i;
   logic [8:0]        id_ctrl_i;
   logic              stall_o, ex_valid_o;
   logic [REG_AW-1:0] ex_rs_o, ex_rt_o, ex_rd_o;
   logic [DATA_W-1:0] ex_data1_o, ex_data2_o, ex_imm_o;
   logic [7:0]        ex_ctrl_o;
`ifdef ID_EX_PERF_EN
   logic [31:0]       bubble_cnt_o;
`endif

   int checks = 0;
   int errors = 0;

   id_ex_pipe #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .hold_i     (hold_i),
      .flush_i    (flush_i),
      .id_rs_i    (id_rs_i),
      .id_rt_i    (id_rt_i),
      .id_rd_i    (id_rd_i),
      .id_data1_i (id_data1_i),
      .id_data2_i (id_data2_i),
      .id_imm_i   (id_imm_i),
      .id_ctrl_i  (id_ctrl_i),
      .stall_o    (stall_o),
      .ex_valid_o (ex_valid_o),
      .ex_rs_o    (ex_rs_o),
      .ex_rt_o    (ex_rt_o),
      .ex_rd_o    (ex_rd_o),
      .ex_data1_o (ex_data1_o),
      .ex_data2_o (ex_data2_o),
      .ex_imm_o   (ex_imm_o),
`ifdef ID_EX_PERF_EN
      .bubble_cnt_o (bubble_cnt_o),
`endif
      .ex_ctrl_o  (ex_ctrl_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                         input logic [8:0] ctrl);
      id_rs_i    = rs;
      id_rt_i    = rt;
      id_rd_i    = rd;
      id_data1_i = d1;
      id_data2_i = d2;
      id_imm_i   = imm;
      id_ctrl_i  = ctrl;
   endtask

   task automatic check_bubble(input string tag);
      check({tag, " valid"}, 32'(ex_valid_o), 32'd0);
      check({tag, " ctrl"},  32'(ex_ctrl_o),  32'd0);
      check({tag, " rt"},    32'(ex_rt_o),    32'd0);
      check({tag, " data1"}, ex_data1_o,      32'd0);
   endtask

   task automatic check_cnt(input string tag, input logic [31:0] expected);
`ifdef ID_EX_PERF_EN
      check(tag, bubble_cnt_o, expected);
`else
      if (expected == 32'hFFFF_FFFF) $display("unused %s", tag);
`endif
   endtask

   initial begin
      rst_i   = 1'b0;
      hold_i  = 1'b0;
      flush_i = 1'b0;
      set_id(5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 9'd0);
      #1;
      check("reset valid", 32'(ex_valid_o), 32'd0);
      check("reset stall", 32'(stall_o), 32'd0);
      check_cnt("reset cnt", 32'd0);
      #10 rst_i = 1'b1;

      // Reset mid-stream: add with data1 = 0x11, then reset between edges.
      set_id(5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h0, C_ADD);
      tick();
      check("add data1", ex_data1_o, 32'h11);
      check("add valid", 32'(ex_valid_o), 32'd1);
      #2 rst_i = 1'b0;
      #1;
      check_bubble("midreset");
      check("midreset rd", 32'(ex_rd_o), 32'd0);
      check("midreset imm", ex_imm_o, 32'd0);
      #1 rst_i = 1'b1;

      // Plain pass-through.
      set_id(5'd3, 5'd4, 5'd5, 32'hDEADBEEF, 32'h12345678, 32'hFFFFFFF0, C_PASS);
      tick();
      check("pass rs",    32'(ex_rs_o), 32'd3);
      check("pass rt",    32'(ex_rt_o), 32'd4);
      check("pass rd",    32'(ex_rd_o), 32'd5);
      check("pass data1", ex_data1_o, 32'hDEADBEEF);
      check("pass data2", ex_data2_o, 32'h12345678);
      check("pass imm",   ex_imm_o,   32'hFFFFFFF0);
      check("pass ctrl",  32'(ex_ctrl_o), 32'h84);
      check("pass valid", 32'(ex_valid_o), 32'd1);
      check("pass stall", 32'(stall_o), 32'd0);

      // Load-use: lw r8 then add using r8.
      set_id(5'd2, 5'd8, 5'd0, 32'h100, 32'h0, 32'h4, C_LW);
      tick();
      check("lw ctrl", 32'(ex_ctrl_o), 32'hE8);
      set_id(5'd8, 5'd6, 5'd10, 32'hA5A5, 32'h5A5A, 32'h0, C_ADD);
      #1;
      check("lu stall", 32'(stall_o), 32'd1);
      tick();
      check_bubble("lu bubble");
      check("lu stall clear", 32'(stall_o), 32'd0);
      check_cnt("lu cnt", 32'd1);
      tick();
      check("lu add valid", 32'(ex_valid_o), 32'd1);
      check("lu add rs", 32'(ex_rs_o), 32'd8);
      check("lu add data1", ex_data1_o, 32'hA5A5);
      check("lu add rd", 32'(ex_rd_o), 32'd10);
      check_cnt("lu cnt after", 32'd1);

      // Register zero never hazards.
      set_id(5'd2, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, C_LW);
      tick();
      set_id(5'd0, 5'd0, 5'd11, 32'h7, 32'h0, 32'h0, C_ADD);
      #1;
      check("r0 stall", 32'(stall_o), 32'd0);
      tick();
      check("r0 valid", 32'(ex_valid_o), 32'd1);

      // uses_rt masking: rt match only counts when uses_rt = 1.
      set_id(5'd2, 5'd9, 5'd0, 32'h0, 32'h0, 32'h0, C_LW);
      tick();
      set_id(5'd1, 5'd9, 5'd12, 32'h0, 32'h0, 32'h0, C_PASS);
      #1;
      check("rt masked stall", 32'(stall_o), 32'd0);
      id_ctrl_i = C_ADD;
      #1;
      check("rt used stall", 32'(stall_o), 32'd1);
      id_ctrl_i = C_PASS;
      tick();
      check("rt masked valid", 32'(ex_valid_o), 32'd1);
      check("rt masked rt", 32'(ex_rt_o), 32'd9);

      // Flush with hazard: single bubble, no stall, counter unchanged.
      set_id(5'd2, 5'd7, 5'd0, 32'h0, 32'h0, 32'h0, C_LW);
      tick();
      set_id(5'd7, 5'd1, 5'd13, 32'h33, 32'h0, 32'h0, C_ADD);
      #1;
      check("flush pre stall", 32'(stall_o), 32'd1);
      flush_i = 1'b1;
      #1;
      check("flush stall", 32'(stall_o), 32'd0);
      tick();
      flush_i = 1'b0;
      check_bubble("flush bubble");
      check_cnt("flush cnt", 32'd1);

      // Hold for 3 cycles with an active hazard and changing ID inputs.
      set_id(5'd2, 5'd7, 5'd0, 32'h44, 32'h0, 32'h0, C_LW);
      tick();
      hold_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_id(5'd7, 5'd3, 5'(14 + i), 32'(32'h50 + i), 32'h0, 32'h0, C_ADD);
         #1;
         check("hold stall", 32'(stall_o), 32'd0);
         tick();
         check("hold rt", 32'(ex_rt_o), 32'd7);
         check("hold ctrl", 32'(ex_ctrl_o), 32'hE8);
         check("hold data1", ex_data1_o, 32'h44);
         check("hold valid", 32'(ex_valid_o), 32'd1);
         check_cnt("hold cnt", 32'd1);
      end
      hold_i = 1'b0;
      #1;
      check("release stall", 32'(stall_o), 32'd1);
      tick();
      check_bubble("release bubble");
      check_cnt("release cnt", 32'd2);
      tick();
      check("release add rd", 32'(ex_rd_o), 32'd16);
      check("release add data1", ex_data1_o, 32'h52);

      // Back-to-back load chain: lw r8; lw r9 <- r8; add <- r9.
      set_id(5'd2, 5'd8, 5'd0, 32'h0, 32'h0, 32'h0, C_LW);
      tick();
      set_id(5'd8, 5'd9, 5'd0, 32'h0, 32'h0, 32'h8, C_LW);
      #1;
      check("chain stall1", 32'(stall_o), 32'd1);
      tick();
      check("chain bubble1", 32'(ex_valid_o), 32'd0);
      tick();
      check("chain lw2 rt", 32'(ex_rt_o), 32'd9);
      check("chain lw2 imm", ex_imm_o, 32'h8);
      set_id(5'd1, 5'd9, 5'd20, 32'h0, 32'h0, 32'h0, C_ADD);
      #1;
      check("chain stall2", 32'(stall_o), 32'd1);
      tick();
      check("chain bubble2", 32'(ex_valid_o), 32'd0);
      check_cnt("chain cnt", 32'd4);
      tick();
      check("chain add rd", 32'(ex_rd_o), 32'd20);
      check("chain add stall", 32'(stall_o), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
